// File: rtl/fa16_arb_if.sv
// fa16_arb_if: request, adder and response signals between clients, the fa16_arb
// arbiter and its shared fa16 adder.
// Latency: none (wiring only). Backpressure: req_ready per requester, rsp_ready on the response.
// Ports (signals):
//   req_valid/req_ready [N_REQ]  per-requester handshake, one-hot ready
//   req_a/req_b [16*N_REQ]       operand packing, requester i at [16i+15:16i]
//   req_cin/req_sub [N_REQ]      carry-in and subtract request per requester
//   add_a/add_b/add_cin          arbiter -> fa16 operands
//   add_s/add_cout               fa16 -> arbiter result
//   rsp_valid/rsp_ready          response FIFO head handshake
//   rsp_id/rsp_sum/rsp_cout      response FIFO head contents
// Modports: slave = arbiter side, master = client/adder side.
interface fa16_arb_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [16*N_REQ-1:0] req_a;
  logic [16*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_cin;
  logic [N_REQ-1:0]    req_sub;

  logic [15:0]         add_a;
  logic [15:0]         add_b;
  logic                add_cin;
  logic [15:0]         add_s;
  logic                add_cout;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [15:0]         rsp_sum;
  logic                rsp_cout;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_sub,
    input  add_s, add_cout,
    input  rsp_ready,
    output req_ready,
    output add_a, add_b, add_cin,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, req_sub,
    output add_s, add_cout,
    output rsp_ready,
    input  req_ready,
    input  add_a, add_b, add_cin,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/fa16_arb.sv
// fa16_arb: round-robin arbiter sharing one 2-cycle registered fa16 adder between N_REQ requesters.
// Latency: accept at edge n, response at the FIFO head in the cycle after edge n+2 (2 cycles).
// Backpressure: issue only while tags in flight + FIFO occupancy - same-cycle pop < FIFO_DEPTH.
// Ports:
//   CLK        sole clock, rising edge
//   RST        synchronous active-high reset (clears rr_ptr, tag pipeline and FIFO)
//   bus        fa16_arb_if.slave: request handshakes, fa16 operand/result, response FIFO head
// Parameters: N_REQ (2..8) requesters, FIFO_DEPTH (power of two, >= 2) response entries.
// Optional feature: define FA16_SUB_EN to honour req_sub (A - B as A + ~B + 1).
module fa16_arb #(
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      CLK,
  input  logic      RST,
  fa16_arb_if.slave bus
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [15:0]     sum;
    logic            cout;
  } rsp_t;

  // ------------------------------------------------------------------
  // Operand unpacking
  // ------------------------------------------------------------------
  logic [15:0] op_a [N_REQ];
  logic [15:0] op_b [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign op_a[g] = bus.req_a[16*g +: 16];
    assign op_b[g] = bus.req_b[16*g +: 16];
  end

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [ID_W-1:0] rr_ptr;
  logic [1:0]      tag_vld;
  logic [ID_W-1:0] tag_id [2];

  rsp_t            mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_count;

  logic            gnt_vld;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] scan_idx;
  logic            credit_ok;
  logic            issue;
  logic            push;
  logic            pop;
  int              occ;
  rsp_t            head;

  // ------------------------------------------------------------------
  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  // ------------------------------------------------------------------
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!gnt_vld && bus.req_valid[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = scan_idx;
      end
    end
  end

  // ------------------------------------------------------------------
  // Credit check. Every tag in flight will land in the FIFO, so it owns a
  // slot already; a pop in this cycle hands its slot back immediately.
  // ------------------------------------------------------------------
  assign pop  = bus.rsp_valid & bus.rsp_ready;
  assign push = tag_vld[1];

  always_comb begin
    occ       = int'(fifo_count) + int'(tag_vld[0]) + int'(tag_vld[1]) - int'(pop);
    credit_ok = !RST && (occ < FIFO_DEPTH);
    issue     = gnt_vld && credit_ok;
  end

  // ------------------------------------------------------------------
  // Accept and adder drive. Operands are zero whenever nothing is issued so
  // the adder sees a quiet bus.
  // ------------------------------------------------------------------
  always_comb begin
    bus.req_ready = '0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    bus.add_cin   = 1'b0;
    if (issue) begin
      bus.req_ready = N_REQ'(1) << gnt_id;
      bus.add_a     = op_a[gnt_id];
`ifdef FA16_SUB_EN
      if (bus.req_sub[gnt_id]) begin
        bus.add_b   = ~op_b[gnt_id];
        bus.add_cin = 1'b1;
      end else begin
        bus.add_b   = op_b[gnt_id];
        bus.add_cin = bus.req_cin[gnt_id];
      end
`else
      bus.add_b     = op_b[gnt_id];
      bus.add_cin   = bus.req_cin[gnt_id];
`endif
    end
  end

`ifndef FA16_SUB_EN
  logic unused_sub;
  assign unused_sub = ^bus.req_sub;
`endif

  // ------------------------------------------------------------------
  // Pointer, tag pipeline and FIFO control
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr     <= '0;
      tag_vld    <= '0;
      tag_id[0]  <= '0;
      tag_id[1]  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (issue) begin
        rr_ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end

      // Tags track the two fa16 register stages one-for-one.
      tag_vld   <= {tag_vld[0], issue};
      tag_id[0] <= gnt_id;
      tag_id[1] <= tag_id[0];

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage carries no reset; pointers and count define what is live.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {tag_id[1], bus.add_s, bus.add_cout};
    end
  end

  // ------------------------------------------------------------------
  // Response head: data forced to zero while empty so consumers never see
  // leftover entries.
  // ------------------------------------------------------------------
  assign head          = mem[rd_ptr];
  assign bus.rsp_valid = (fifo_count != '0);
  assign bus.rsp_id    = bus.rsp_valid ? head.id   : '0;
  assign bus.rsp_sum   = bus.rsp_valid ? head.sum  : '0;
  assign bus.rsp_cout  = bus.rsp_valid ? head.cout : 1'b0;

  // ------------------------------------------------------------------
  // Simulation-only sanity checks
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));
      assert ($onehot0(bus.req_ready));
      assert (int'(rr_ptr) < N_REQ);
    end
  end

endmodule
